noc_rr_timeout_arbiter: RTL and testbench

- Parametrised N-port router output arbiter with per-port packet timers.
- Generalises the fixed 5-port L/N/E/W/S arbiter: any port count, configurable length/flit-id widths, rotating priority out of idle, and registered encoded-grant and timeout-event outputs.
- Sits in the router between input-port request logic and the crossbar select.

---
 rtl/noc_rr_timeout_arbiter.sv | 123 ++++++++++++
 tb/tb_noc_rr_timeout_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_rr_timeout_arbiter.sv
// N-port router output arbiter: rotating priority out of idle, per-port packet timers
// that force a grant release after limit+1 cycles, registered grant and timeout outputs.
module noc_rr_timeout_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int LEN_W     = 12,
  parameter int FID_W     = 3,
  parameter int HEADER_ID = 1,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS*FID_W-1:0] flit_id,
  input  logic [NUM_PORTS*LEN_W-1:0] length,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       grant_valid,
  output logic [IDX_W-1:0]           grant_idx,
  output logic [NUM_PORTS-1:0]       timeout
);

  localparam logic [FID_W-1:0] HDR = FID_W'(HEADER_ID);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     cur, cur_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;
  logic [IDX_W-1:0]     pick;
  logic                 hit;
  int                   base, pos;
  logic [LEN_W-1:0]     limit [NUM_PORTS];
  logic [LEN_W-1:0]     count [NUM_PORTS];
  logic [NUM_PORTS-1:0] timesup, run, timeout_nxt;

  always_comb begin
    timesup = '0;
    for (int i = 0; i < NUM_PORTS; i++) timesup[i] = (count[i] == limit[i]);
  end

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    ptr_nxt     = ptr;
    run         = '0;
    timeout_nxt = '0;
    hit         = 1'b0;
    pick        = '0;
    base        = 0;
    pos         = 0;
    case (state)
      S_IDLE: begin
        base = int'(ptr);
        for (int k = 0; k < NUM_PORTS; k++) begin
          pos = base + k;
          if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
          if (!hit && req[IDX_W'(pos)]) begin
            hit  = 1'b1;
            pick = IDX_W'(pos);
          end
        end
        if (hit) begin
          state_nxt = S_GRANT;
          cur_nxt   = pick;
        end
      end
      S_GRANT: begin
        if (int'(cur) >= NUM_PORTS) begin
          state_nxt = S_IDLE;
        end else if (req[cur] && !timesup[cur]) begin
          run[cur] = 1'b1;
        end else begin
          // Release: a still-requesting owner was cut off by its timer.
          timeout_nxt[cur] = req[cur];
          base    = int'(cur);
          ptr_nxt = (base == NUM_PORTS - 1) ? '0 : IDX_W'(base + 1);
          for (int k = 1; k < NUM_PORTS; k++) begin
            pos = base + k;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            if (!hit && req[IDX_W'(pos)]) begin
              hit  = 1'b1;
              pick = IDX_W'(pos);
            end
          end
          state_nxt = hit ? S_GRANT : S_IDLE;
          cur_nxt   = hit ? pick : cur;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cur     <= '0;
      ptr     <= '0;
      timeout <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        count[i] <= '0;
        limit[i] <= '1;
      end
    end else begin
      state   <= state_nxt;
      cur     <= cur_nxt;
      ptr     <= ptr_nxt;
      timeout <= timeout_nxt;
      for (int i = 0; i < NUM_PORTS; i++) begin
        count[i] <= run[i] ? count[i] + 1'b1 : '0;
        // Header reloads the limit regardless of grant; compare sees it next cycle.
        if (flit_id[i*FID_W +: FID_W] == HDR) limit[i] <= length[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == S_GRANT) grant[cur] = 1'b1;
  end

  assign grant_valid = |grant;
  assign grant_idx   = (state == S_GRANT) ? cur : '0;

endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// Bench for noc_rr_timeout_arbiter: directed vector table for the corner sequences,
// then random traffic checked against a cycle-level packet/ownership model.
module tb_noc_rr_timeout_arbiter;

  localparam int N     = 5;
  localparam int LW    = 12;
  localparam int FW    = 3;
  localparam int IW    = 3;
  localparam int LMASK = (1 << LW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*FW-1:0] flit_id = '0;
  logic [N*LW-1:0] length = '0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [N-1:0]    timeout;

  int errors = 0;
  int checks = 0;

  noc_rr_timeout_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .length(length),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] hdr;
    logic [LW-1:0] len;
    logic [N-1:0] eg;
    logic [N-1:0] et;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] h,
                     input int ln, input logic [N-1:0] eg, input logic [N-1:0] et);
    vec_t v;
    v.rst = r; v.req = rq; v.hdr = h; v.len = LW'(ln); v.eg = eg; v.et = et;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [N-1:0] eg, input logic [N-1:0] et);
    logic [IW-1:0] ei;
    ei = '0;
    for (int i = 0; i < N; i++) if (eg[i]) ei = IW'(i);
    checks++;
    if (grant !== eg || grant_valid !== (|eg) || grant_idx !== ei || timeout !== et) begin
      errors++;
      $display("FAIL %s: got grant=%b valid=%b idx=%0d timeout=%b, want grant=%b valid=%b idx=%0d timeout=%b",
               nm, grant, grant_valid, grant_idx, timeout, eg, |eg, ei, et);
    end
  endtask

  // Model: owner (-1 = idle), cycles held so far, rotation pointer, per-port limits.
  int           m_owner, m_ptr, m_held;
  int           m_lim [N];
  logic [N-1:0] m_to;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_to = '0;
    for (int p = 0; p < N; p++) m_lim[p] = LMASK;
  endfunction

  function automatic void model_step();
    int o, p;
    bit found, expired;
    if (rst) begin
      model_reset();
      return;
    end
    m_to = '0;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (!found && req[p]) begin found = 1; m_owner = p; m_held = 1; end
      end
    end else begin
      expired = (((m_held - 1) % (LMASK + 1)) == m_lim[m_owner]);
      if (req[m_owner] && !expired) begin
        m_held++;
      end else begin
        o = m_owner;
        if (req[o]) m_to[o] = 1'b1;
        m_ptr = (o + 1) % N;
        m_owner = -1;
        for (int k = 1; k < N; k++) begin
          p = (o + k) % N;
          if (!found && req[p]) begin found = 1; m_owner = p; m_held = 1; end
        end
      end
    end
    for (int q = 0; q < N; q++)
      if (flit_id[q*FW +: FW] == 3'd1) m_lim[q] = int'(length[q*LW +: LW]);
  endfunction

  initial begin
    logic [N-1:0] meg;
    // reset and idle
    add(1, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // ptr=0 scan picks port 1, voluntary release hands over to 2
    add(0, 5'b10110, 0, 0, 5'b00010, 0);
    add(0, 5'b10110, 0, 0, 5'b00010, 0);
    add(0, 5'b10110, 0, 0, 5'b00010, 0);
    add(0, 5'b10100, 0, 0, 5'b00100, 0);
    add(0, 5'b10100, 0, 0, 5'b00100, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // port 3 length 4: five grant cycles, pulse, one idle, regrant
    add(0, 5'b00000, 5'b01000, 4, 5'b00000, 0);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b01000, 0, 0, 5'b00000, 5'b01000);
    add(0, 5'b01000, 0, 0, 5'b01000, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // ports 0 and 2 length 2 alternate every 3 cycles
    add(0, 5'b00000, 5'b00101, 2, 5'b00000, 0);
    add(0, 5'b00101, 0, 0, 5'b00001, 0);
    add(0, 5'b00101, 0, 0, 5'b00001, 0);
    add(0, 5'b00101, 0, 0, 5'b00001, 0);
    add(0, 5'b00101, 0, 0, 5'b00100, 5'b00001);
    add(0, 5'b00101, 0, 0, 5'b00100, 0);
    add(0, 5'b00101, 0, 0, 5'b00100, 0);
    add(0, 5'b00101, 0, 0, 5'b00001, 5'b00100);
    add(0, 5'b00101, 0, 0, 5'b00001, 0);
    add(0, 5'b00101, 0, 0, 5'b00001, 0);
    add(0, 5'b00101, 0, 0, 5'b00100, 5'b00001);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // port 1 limit 0: single-cycle grants with an idle gap
    add(0, 5'b00000, 5'b00010, 0, 5'b00000, 0);
    add(0, 5'b00010, 0, 0, 5'b00010, 0);
    add(0, 5'b00010, 0, 0, 5'b00000, 5'b00010);
    add(0, 5'b00010, 0, 0, 5'b00010, 0);
    add(0, 5'b00010, 0, 0, 5'b00000, 5'b00010);
    add(0, 5'b00010, 0, 0, 5'b00010, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // reset during GRANT(2) with count=3, scan restarts at port 0
    add(0, 5'b00000, 5'b00100, 10, 5'b00000, 0);
    add(0, 5'b00100, 0, 0, 5'b00100, 0);
    add(0, 5'b00100, 0, 0, 5'b00100, 0);
    add(0, 5'b00100, 0, 0, 5'b00100, 0);
    add(0, 5'b00100, 0, 0, 5'b00100, 0);
    add(1, 5'b00100, 0, 0, 5'b00000, 0);
    add(0, 5'b11111, 0, 0, 5'b00001, 0);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);
    // header reload on the timeout cycle: old limit 1 times out, new limit 3 next grant
    add(0, 5'b00000, 5'b10000, 1, 5'b00000, 0);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 5'b10000, 3, 5'b00000, 5'b10000);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 0, 0, 5'b10000, 0);
    add(0, 5'b10000, 0, 0, 5'b00000, 5'b10000);
    add(0, 5'b00000, 0, 0, 5'b00000, 0);

    for (int n = 0; n < vq.size(); n++) begin
      rst = vq[n].rst;
      req = vq[n].req;
      for (int p = 0; p < N; p++) begin
        flit_id[p*FW +: FW] = vq[n].hdr[p] ? 3'd1 : 3'd0;
        length[p*LW +: LW]  = vq[n].len;
      end
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", n), vq[n].eg, vq[n].et);
    end

    // random traffic against the model
    rst = 1'b1; req = '0; flit_id = '0; length = '0;
    @(posedge clk);
    model_reset();
    #1;
    check("rand_reset", '0, '0);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int p = 0; p < N; p++) begin
        req[p] = ($urandom_range(0, 9) < 6);
        flit_id[p*FW +: FW] = FW'($urandom_range(0, 7));
        length[p*LW +: LW]  = LW'($urandom_range(0, 6));
      end
      @(posedge clk);
      model_step();
      #1;
      meg = '0;
      if (m_owner >= 0) meg[m_owner] = 1'b1;
      check($sformatf("rand%0d", c), meg, m_to);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
